// File: rtl/flit_link_pkg.sv
// Shared definitions for the point-to-point flit link: default widths and the flit type.
package flit_link_pkg;

  localparam int unsigned DEF_FLIT_WIDTH = 128;
  localparam int unsigned DEF_CNT_W      = 16;

  typedef logic [DEF_FLIT_WIDTH-1:0] flit_t;

endpackage

// File: rtl/flit_link_fifo.sv
// First-word-fall-through receive FIFO for one link direction.
// A write is taken when not full, or when full and a pop happens in the same cycle.
module flit_link_fifo
  import flit_link_pkg::*;
#(
  parameter int unsigned FLIT_WIDTH = DEF_FLIT_WIDTH,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_vld,
  input  logic [FLIT_WIDTH-1:0]        wr_data,
  output logic [FLIT_WIDTH-1:0]        rd_data,
  output logic                         rd_vld,
  input  logic                         rd_rdy,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = $clog2(DEPTH+1);

  logic [FLIT_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [LVL_W-1:0]      level_nxt;
  logic                  push;
  logic                  pop;

  assign pop  = rd_vld & rd_rdy;
  assign push = wr_vld & (~full | pop);

  // Occupancy after this cycle's push/pop.
  always_comb begin
    level_nxt = level;
    if (push && !pop) begin
      level_nxt = level + LVL_W'(1);
    end else if (pop && !push) begin
      level_nxt = level - LVL_W'(1);
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two; status flags are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      rd_vld <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      level  <= level_nxt;
      full   <= (level_nxt == LVL_W'(DEPTH));
      empty  <= (level_nxt == '0);
      rd_vld <= (level_nxt != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Head entry; stable while it is not popped.
  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/flit_link.sv
// Bidirectional chip-to-chip flit link: per direction a wire-delay pipeline feeding a
// receive FIFO, with overflow drop counting and link-enable gating.
module flit_link
  import flit_link_pkg::*;
#(
  parameter int unsigned FLIT_WIDTH = DEF_FLIT_WIDTH,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned LINK_DELAY = 1,
  parameter int unsigned CNT_W      = DEF_CNT_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        link_en,
  input  logic [FLIT_WIDTH-1:0]       a_flit_tx,
  input  logic                        a_flit_tx_vld,
  output logic [FLIT_WIDTH-1:0]       b_flit_rx,
  output logic                        b_flit_rx_vld,
  input  logic                        b_flit_rx_rdy,
  input  logic [FLIT_WIDTH-1:0]       b_flit_tx,
  input  logic                        b_flit_tx_vld,
  output logic [FLIT_WIDTH-1:0]       a_flit_rx,
  output logic                        a_flit_rx_vld,
  input  logic                        a_flit_rx_rdy,
  output logic [CNT_W-1:0]            a2b_drop_cnt,
  output logic [CNT_W-1:0]            b2a_drop_cnt,
  output logic                        a2b_ovf,
  output logic                        b2a_ovf,
  output logic [$clog2(DEPTH+1)-1:0]  a2b_level,
  output logic [$clog2(DEPTH+1)-1:0]  b2a_level
);

  localparam int unsigned LVL_W = $clog2(DEPTH+1);

  // Index 0 is the A->B direction, index 1 is B->A.
  logic [1:0][FLIT_WIDTH-1:0] tx_data;
  logic [1:0]                 tx_vld;
  logic [1:0]                 rx_rdy;

  assign tx_data = {b_flit_tx, a_flit_tx};
  assign tx_vld  = {b_flit_tx_vld, a_flit_tx_vld};
  assign rx_rdy  = {a_flit_rx_rdy, b_flit_rx_rdy};

  for (genvar d = 0; d < 2; d++) begin : g_dir
    localparam int unsigned DLY_BITS = LINK_DELAY * FLIT_WIDTH;

    logic [LINK_DELAY-1:0]                 dly_vld;
    logic [LINK_DELAY-1:0][FLIT_WIDTH-1:0] dly_data;
    logic                                  push;
    logic                                  pop;
    logic                                  drop;
    logic                                  full;
    logic                                  empty;
    logic [FLIT_WIDTH-1:0]                 rx_data;
    logic                                  rx_vld;
    logic [LVL_W-1:0]                      level;
    logic [CNT_W-1:0]                      drop_cnt;
    logic                                  ovf;

    // Wire-delay valid shift; a dropped link flushes everything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dly_vld <= '0;
      end else if (!link_en) begin
        dly_vld <= '0;
      end else begin
        dly_vld <= LINK_DELAY'({dly_vld, tx_vld[d]});
      end
    end

    always_ff @(posedge clk) begin
      dly_data <= DLY_BITS'({dly_data, tx_data[d]});
    end

    // Gating on link_en makes the flush cover the stage being written this cycle.
    assign push = dly_vld[LINK_DELAY-1] & link_en;
    assign pop  = ~empty & rx_rdy[d];
    assign drop = push & full & ~pop;

    flit_link_fifo #(
      .FLIT_WIDTH (FLIT_WIDTH),
      .DEPTH      (DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_vld  (push),
      .wr_data (dly_data[LINK_DELAY-1]),
      .rd_data (rx_data),
      .rd_vld  (rx_vld),
      .rd_rdy  (rx_rdy[d]),
      .full    (full),
      .empty   (empty),
      .level   (level)
    );

    // Saturating drop counter and sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        drop_cnt <= '0;
        ovf      <= 1'b0;
      end else if (drop) begin
        ovf <= 1'b1;
        if (drop_cnt != '1) begin
          drop_cnt <= drop_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign b_flit_rx     = g_dir[0].rx_data;
  assign b_flit_rx_vld = g_dir[0].rx_vld;
  assign a2b_level     = g_dir[0].level;
  assign a2b_drop_cnt  = g_dir[0].drop_cnt;
  assign a2b_ovf       = g_dir[0].ovf;

  assign a_flit_rx     = g_dir[1].rx_data;
  assign a_flit_rx_vld = g_dir[1].rx_vld;
  assign b2a_level     = g_dir[1].level;
  assign b2a_drop_cnt  = g_dir[1].drop_cnt;
  assign b2a_ovf       = g_dir[1].ovf;

endmodule

// File: tb/tb_flit_link.sv
// Randomized and directed bench for flit_link with a queue-based reference model and
// a scoreboard monitor checking delivery, occupancy, drop count and overflow.
module tb_flit_link;
  import flit_link_pkg::*;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned LD      = 2;
  localparam int unsigned CW      = 4;
  localparam int unsigned CNT_MAX = (1 << CW) - 1;

  logic        clk;
  logic        rst_n;
  logic        link_en;
  flit_t       a_flit_tx, b_flit_tx, a_flit_rx, b_flit_rx;
  logic        a_flit_tx_vld, b_flit_tx_vld;
  logic        a_flit_rx_vld, b_flit_rx_vld;
  logic        a_flit_rx_rdy, b_flit_rx_rdy;
  logic [CW-1:0] a2b_drop_cnt, b2a_drop_cnt;
  logic        a2b_ovf, b2a_ovf;
  logic [2:0]  a2b_level, b2a_level;

  flit_link #(
    .FLIT_WIDTH (DEF_FLIT_WIDTH),
    .DEPTH      (DEPTH),
    .LINK_DELAY (LD),
    .CNT_W      (CW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .link_en       (link_en),
    .a_flit_tx     (a_flit_tx),
    .a_flit_tx_vld (a_flit_tx_vld),
    .b_flit_rx     (b_flit_rx),
    .b_flit_rx_vld (b_flit_rx_vld),
    .b_flit_rx_rdy (b_flit_rx_rdy),
    .b_flit_tx     (b_flit_tx),
    .b_flit_tx_vld (b_flit_tx_vld),
    .a_flit_rx     (a_flit_rx),
    .a_flit_rx_vld (a_flit_rx_vld),
    .a_flit_rx_rdy (a_flit_rx_rdy),
    .a2b_drop_cnt  (a2b_drop_cnt),
    .b2a_drop_cnt  (b2a_drop_cnt),
    .a2b_ovf       (a2b_ovf),
    .b2a_ovf       (b2a_ovf),
    .a2b_level     (a2b_level),
    .b2a_level     (b2a_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Reference model: flits in flight carry the cycle they reach the receiver; the
  // expected queue is the receiver buffer contents in delivery order.
  typedef struct {
    int unsigned arrive;
    flit_t       data;
  } infl_t;

  infl_t       infl [2][$];
  flit_t       exp_q [2][$];
  int unsigned drop_m [2];
  bit          ovf_m [2];
  int unsigned cyc = 0;

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      infl[d].delete();
      exp_q[d].delete();
      drop_m[d] = 0;
      ovf_m[d]  = 1'b0;
    end
  endtask

  initial model_clear();

  // Model advance on each edge, using the inputs of the cycle that just ended.
  always @(posedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        infl_t it;
        logic  v;
        flit_t x;
        v = (d == 0) ? a_flit_tx_vld : b_flit_tx_vld;
        x = (d == 0) ? a_flit_tx : b_flit_tx;
        if (!link_en) begin
          infl[d].delete();
        end else begin
          if (infl[d].size() > 0 && infl[d][0].arrive == cyc) begin
            it = infl[d].pop_front();
            // The monitor has already removed this cycle's pop, so room means accept.
            if (exp_q[d].size() < DEPTH) begin
              exp_q[d].push_back(it.data);
            end else begin
              if (drop_m[d] < CNT_MAX) drop_m[d]++;
              ovf_m[d] = 1'b1;
            end
          end
          if (v) infl[d].push_back('{arrive: cyc + LD, data: x});
        end
      end
      cyc++;
    end
  end

  // Scoreboard monitor: status every cycle, data on each handshake.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic [2:0]    m_lvl;
      logic          m_vld;
      logic          m_rdy;
      logic [CW-1:0] m_drop;
      logic          m_ovf;
      flit_t         m_data;
      flit_t         m_exp;
      string         pfx;
      pfx    = (d == 0) ? "a2b" : "b2a";
      m_lvl  = (d == 0) ? a2b_level : b2a_level;
      m_vld  = (d == 0) ? b_flit_rx_vld : a_flit_rx_vld;
      m_rdy  = (d == 0) ? b_flit_rx_rdy : a_flit_rx_rdy;
      m_drop = (d == 0) ? a2b_drop_cnt : b2a_drop_cnt;
      m_ovf  = (d == 0) ? a2b_ovf : b2a_ovf;
      m_data = (d == 0) ? b_flit_rx : a_flit_rx;
      chk({pfx, "_level"}, 128'(m_lvl), 128'(exp_q[d].size()));
      chk({pfx, "_rx_vld"}, 128'(m_vld), 128'(exp_q[d].size() != 0));
      chk({pfx, "_drop_cnt"}, 128'(m_drop), 128'(drop_m[d]));
      chk({pfx, "_ovf"}, 128'(m_ovf), 128'(ovf_m[d]));
      if (rst_n && exp_q[d].size() > 0 && m_rdy) begin
        m_exp = exp_q[d].pop_front();
        chk({pfx, "_rx_data"}, m_data, m_exp);
      end
    end
  end

  task automatic step(input logic av, input flit_t ad, input logic bv, input flit_t bd,
                      input logic ardy, input logic brdy, input logic en);
    a_flit_tx_vld = av;
    a_flit_tx     = ad;
    b_flit_tx_vld = bv;
    b_flit_tx     = bd;
    a_flit_rx_rdy = ardy;
    b_flit_rx_rdy = brdy;
    link_en       = en;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ardy, input logic brdy, input logic en);
    step(1'b0, '0, 1'b0, '0, ardy, brdy, en);
  endtask

  task automatic do_reset();
    a_flit_tx_vld = 1'b0;
    b_flit_tx_vld = 1'b0;
    rst_n = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic flit_t rnd_flit();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    rst_n = 1'b0;
    link_en = 1'b1;
    a_flit_tx = '0; b_flit_tx = '0;
    a_flit_tx_vld = 1'b0; b_flit_tx_vld = 1'b0;
    a_flit_rx_rdy = 1'b0; b_flit_rx_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) idle(1'b1, 1'b1, 1'b1);

    // Single flit latency.
    step(1'b1, flit_t'(8'h11), 1'b0, '0, 1'b1, 1'b1, 1'b1);
    repeat (6) idle(1'b1, 1'b1, 1'b1);

    // Overflow with receiver stalled, then drain.
    for (int i = 1; i <= 6; i++) step(1'b1, flit_t'(i), 1'b0, '0, 1'b0, 1'b0, 1'b1);
    repeat (4) idle(1'b0, 1'b0, 1'b1);
    chk("ovf_level", 128'(a2b_level), 128'(4));
    chk("ovf_drop_cnt", 128'(a2b_drop_cnt), 128'(2));
    chk("ovf_flag", 128'(a2b_ovf), 128'(1));
    repeat (8) idle(1'b1, 1'b1, 1'b1);

    // Write into a full FIFO coinciding with a pop.
    do_reset();
    for (int i = 1; i <= 5; i++) step(1'b1, flit_t'(i), 1'b0, '0, 1'b0, 1'b0, 1'b1);
    idle(1'b0, 1'b0, 1'b1);
    idle(1'b0, 1'b1, 1'b1);
    repeat (3) idle(1'b0, 1'b0, 1'b1);
    chk("full_pop_level", 128'(a2b_level), 128'(4));
    chk("full_pop_drop", 128'(a2b_drop_cnt), 128'(0));
    repeat (8) idle(1'b1, 1'b1, 1'b1);

    // Link drop with flits both in flight and buffered.
    do_reset();
    for (int i = 1; i <= 4; i++) step(1'b1, flit_t'(8'h20 + i), 1'b0, '0, 1'b0, 1'b0, 1'b1);
    repeat (3) idle(1'b0, 1'b0, 1'b0);
    chk("linkdn_level", 128'(a2b_level), 128'(2));
    chk("linkdn_drop", 128'(a2b_drop_cnt), 128'(0));
    repeat (6) idle(1'b1, 1'b1, 1'b1);
    chk("linkdn_drained", 128'(a2b_level), 128'(0));

    // Concurrent streams in both directions.
    do_reset();
    for (int i = 0; i < 8; i++)
      step(1'b1, flit_t'(8'hA0 + i), 1'b1, flit_t'(8'hB0 + i), 1'b1, 1'b1, 1'b1);
    repeat (6) idle(1'b1, 1'b1, 1'b1);

    // Drop counter saturation.
    do_reset();
    for (int i = 0; i < 25; i++) step(1'b1, rnd_flit(), 1'b1, rnd_flit(), 1'b0, 1'b0, 1'b1);
    repeat (4) idle(1'b0, 1'b0, 1'b1);
    chk("sat_drop_cnt", 128'(a2b_drop_cnt), 128'(CNT_MAX));
    chk("sat_b2a_drop", 128'(b2a_drop_cnt), 128'(CNT_MAX));
    repeat (6) idle(1'b1, 1'b1, 1'b1);

    // Reset mid-operation.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, rnd_flit(), 1'b0, '0, 1'b0, 1'b0, 1'b1);
    repeat (3) idle(1'b0, 1'b0, 1'b1);
    step(1'b1, rnd_flit(), 1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("pre_rst_level", 128'(a2b_level), 128'(3));
    rst_n = 1'b0;
    model_clear();
    #1;
    chk("rst_rx_vld", 128'(b_flit_rx_vld), 128'(0));
    chk("rst_level", 128'(a2b_level), 128'(0));
    chk("rst_drop", 128'(a2b_drop_cnt), 128'(0));
    chk("rst_ovf", 128'(a2b_ovf), 128'(0));
    a_flit_tx_vld = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) idle(1'b1, 1'b1, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      step($urandom_range(0, 2) != 0, rnd_flit(), $urandom_range(0, 2) != 0, rnd_flit(),
           $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 6, $urandom_range(0, 19) != 0);
    end
    repeat (12) idle(1'b1, 1'b1, 1'b1);
    chk("final_a2b_level", 128'(a2b_level), 128'(0));
    chk("final_b2a_level", 128'(b2a_level), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
